// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI master between two requesters.
// Latches the winner's word and mode, settles CKP/CPH, pulses start and reports completion or timeout.
module spi_xfer_arbiter #(
    parameter int DATA_W    = 16,
    parameter int SETUP_CYC = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,     // active-low, synchronous
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [DATA_W-1:0] i_txd0,
    input  logic [DATA_W-1:0] i_txd1,
    input  logic [1:0]        i_mode0,
    input  logic [1:0]        i_mode1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_done0,
    output logic              o_done1,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rxd,
    output logic              o_m_start,
    output logic [DATA_W-1:0] o_m_txd,
    output logic              o_m_ckp,
    output logic              o_m_cph,
    output logic              o_m_cs_sel,
    input  logic              i_m_done,
    input  logic [DATA_W-1:0] i_m_rxd
);

    localparam int CNT_MAX = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_BUSY,
        ST_COMPLETE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sel;
    logic               r_rr;
    logic               r_err;
    logic               r_ckp;
    logic               r_cph;
    logic [DATA_W-1:0]  r_txd;
    logic [DATA_W-1:0]  r_rxd;
    logic               w_win;
    logic               w_any_req;
    logic               w_timeout;
    logic               w_owned;

    assign w_any_req = i_req0 | i_req1;
    // With both requesting, the round-robin pointer names the one not served last.
    assign w_win     = (i_req0 & i_req1) ? r_rr : i_req1;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (i_m_done || w_timeout) begin
                    w_state_next = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt <= '0;
            r_sel <= 1'b0;
            r_rr  <= 1'b0;
            r_err <= 1'b0;
            r_ckp <= 1'b0;
            r_cph <= 1'b0;
            r_txd <= '0;
            r_rxd <= '0;
        end else begin
            // Mode, word and index are captured only at grant so the SCK idle level never moves in IDLE.
            if (r_state == ST_IDLE && w_any_req) begin
                r_sel <= w_win;
                r_txd <= w_win ? i_txd1 : i_txd0;
                {r_ckp, r_cph} <= w_win ? i_mode1 : i_mode0;
            end

            if (r_state == ST_IDLE || w_state_next != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == ST_BUSY) begin
                r_err <= w_timeout & ~i_m_done;
                if (i_m_done) begin
                    r_rxd <= i_m_rxd;
                end
            end

            if (r_state == ST_COMPLETE) begin
                r_rr <= ~r_sel;
            end
        end
    end

    assign w_owned    = (r_state == ST_SETUP) || (r_state == ST_START) || (r_state == ST_BUSY);
    assign o_gnt0     = w_owned & ~r_sel;
    assign o_gnt1     = w_owned & r_sel;
    assign o_done0    = (r_state == ST_COMPLETE) & ~r_sel;
    assign o_done1    = (r_state == ST_COMPLETE) & r_sel;
    assign o_err      = (r_state == ST_COMPLETE) & r_err;
    assign o_rxd      = r_rxd;
    assign o_m_start  = (r_state == ST_START);
    assign o_m_txd    = r_txd;
    assign o_m_ckp    = r_ckp;
    assign o_m_cph    = r_cph;
    assign o_m_cs_sel = r_sel;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed, table-driven bench for spi_xfer_arbiter with a behavioural SPI master stand-in.
// The master answers M_DONE a fixed number of BUSY cycles after start, or never (lat=0).
module tb_spi_xfer_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] txd0, txd1;
    logic [1:0]  mode0, mode1;
    logic        gnt0, gnt1, done0, done1, err;
    logic [15:0] rxd;
    logic        m_start;
    logic [15:0] m_txd;
    logic        m_ckp, m_cph, m_cs_sel;
    logic        m_done;
    logic [15:0] m_rxd;

    int total = 0;
    int bad   = 0;
    logic [15:0] model_rxd;
    logic        last_ckp;

    always #5 clk = ~clk;

    spi_xfer_arbiter #(.DATA_W(16), .SETUP_CYC(2), .TIMEOUT(64)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_req0     (req0),
        .i_req1     (req1),
        .i_txd0     (txd0),
        .i_txd1     (txd1),
        .i_mode0    (mode0),
        .i_mode1    (mode1),
        .o_gnt0     (gnt0),
        .o_gnt1     (gnt1),
        .o_done0    (done0),
        .o_done1    (done1),
        .o_err      (err),
        .o_rxd      (rxd),
        .o_m_start  (m_start),
        .o_m_txd    (m_txd),
        .o_m_ckp    (m_ckp),
        .o_m_cph    (m_cph),
        .o_m_cs_sel (m_cs_sel),
        .i_m_done   (m_done),
        .i_m_rxd    (m_rxd)
    );

    typedef struct {
        logic        r0;
        logic        r1;
        logic [15:0] t0;
        logic [15:0] t1;
        logic [1:0]  m0;
        logic [1:0]  m1;
        logic [15:0] mrxd;
        int          lat;   // BUSY cycle carrying M_DONE; 0 = master hangs
        logic        esel;
        logic [15:0] etxd;
        logic        eckp;
        logic        ecph;
        logic        eerr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {24'd0, gnt0, gnt1, done0, done1, err, rxd, m_start, m_txd, m_ckp, m_cph, m_cs_sel};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        int exp_k;
        bit got;
        @(negedge clk);
        chk($sformatf("v%0d idle_gnt", idx), {62'd0, gnt1, gnt0}, 64'd0);
        chk($sformatf("v%0d idle_ckp_hold", idx), {63'd0, m_ckp}, {63'd0, last_ckp});
        req0 = v.r0; req1 = v.r1; txd0 = v.t0; txd1 = v.t1; mode0 = v.m0; mode1 = v.m1;
        @(negedge clk);
        chk($sformatf("v%0d gnt", idx), {62'd0, gnt1, gnt0}, v.esel ? 64'd2 : 64'd1);
        chk($sformatf("v%0d m_txd", idx), {48'd0, m_txd}, {48'd0, v.etxd});
        chk($sformatf("v%0d mode", idx), {62'd0, m_ckp, m_cph}, {62'd0, v.eckp, v.ecph});
        chk($sformatf("v%0d cs_sel", idx), {63'd0, m_cs_sel}, {63'd0, v.esel});
        chk($sformatf("v%0d start_early1", idx), {63'd0, m_start}, 64'd0);
        txd0 = ~txd0; txd1 = ~txd1; mode0 = ~mode0; mode1 = ~mode1;
        @(negedge clk);
        chk($sformatf("v%0d start_early2", idx), {63'd0, m_start}, 64'd0);
        @(negedge clk);
        chk($sformatf("v%0d start", idx), {63'd0, m_start}, 64'd1);
        chk($sformatf("v%0d start_txd", idx), {48'd0, m_txd}, {48'd0, v.etxd});
        chk($sformatf("v%0d start_mode", idx), {62'd0, m_ckp, m_cph}, {62'd0, v.eckp, v.ecph});
        k = 0;
        got = 0;
        while (!got && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) chk($sformatf("v%0d start_1cyc", idx), {63'd0, m_start}, 64'd0);
            if (done0 || done1) begin
                got = 1;
                m_done = 1'b0;
            end else begin
                m_done = (v.lat != 0 && k == v.lat);
                m_rxd  = v.mrxd;
            end
        end
        exp_k = (v.lat == 0) ? 65 : v.lat + 1;
        if (v.lat != 0) model_rxd = v.mrxd;
        chk($sformatf("v%0d done_cycle", idx), 64'(k), 64'(exp_k));
        chk($sformatf("v%0d done_bits", idx), {62'd0, done1, done0}, v.esel ? 64'd2 : 64'd1);
        chk($sformatf("v%0d err", idx), {63'd0, err}, {63'd0, v.eerr});
        chk($sformatf("v%0d rxd", idx), {48'd0, rxd}, {48'd0, model_rxd});
        chk($sformatf("v%0d gnt_drop", idx), {62'd0, gnt1, gnt0}, 64'd0);
        $display("xfer %0d sel=%0d txd=%h rxd=%h err=%0d cycles=%0d", idx, v.esel, m_txd, rxd, err, k);
        req0 = 1'b0; req1 = 1'b0;
        last_ckp = v.eckp;
    endtask

    initial begin
        int k;
        vec_t vb;
        vecs[0] = '{1'b1, 1'b0, 16'h0015, 16'h0000, 2'b00, 2'b00, 16'h0062, 3,  1'b0, 16'h0015, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'h1111, 16'hA5A5, 2'b00, 2'b10, 16'h1234, 2,  1'b1, 16'hA5A5, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h2222, 16'hA5A5, 2'b01, 2'b10, 16'h5678, 4,  1'b0, 16'h2222, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'h3333, 16'hB6B6, 2'b01, 2'b10, 16'h9ABC, 1,  1'b1, 16'hB6B6, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h0F0F, 2'b00, 2'b11, 16'hDEAD, 0,  1'b1, 16'h0F0F, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'h4242, 16'h0000, 2'b00, 2'b00, 16'h1111, 3,  1'b0, 16'h4242, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0000, 16'hC3C3, 2'b00, 2'b10, 16'h2222, 64, 1'b1, 16'hC3C3, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'h5A5A, 16'h0000, 2'b11, 2'b00, 16'h3333, 5,  1'b0, 16'h5A5A, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0;
        txd0 = 16'h0015; txd1 = '0; mode0 = '0; mode1 = '0;
        m_done = 1'b0; m_rxd = '0;
        model_rxd = '0; last_ckp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("reset_outs%0d", i), all_outs(), 64'd0);
        end
        req0 = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Stray M_DONE while idle must not complete anything or touch RXD.
        @(negedge clk);
        m_done = 1'b1; m_rxd = 16'hDEAD;
        @(negedge clk);
        m_done = 1'b0;
        chk("idle_mdone_done", {61'd0, done0, done1, err}, 64'd0);
        chk("idle_mdone_rxd", {48'd0, rxd}, {48'd0, model_rxd});
        @(negedge clk);
        chk("idle_mdone_quiet", {61'd0, gnt0, gnt1, m_start}, 64'd0);

        // Reset during BUSY aborts silently and restores the REQ0 preference.
        req1 = 1'b1; txd1 = 16'h7777; mode1 = 2'b11;
        k = 0;
        while (!m_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reached_start", {63'd0, m_start}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0; m_done = 1'b1; m_rxd = 16'hBEEF;
        @(negedge clk);
        chk("abort_outs0", all_outs(), 64'd0);
        m_done = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("abort_outs1", all_outs(), 64'd0);
        rst_n = 1'b1;
        model_rxd = '0; last_ckp = 1'b0;
        vb = '{1'b1, 1'b1, 16'h6060, 16'h7070, 2'b01, 2'b10, 16'h4444, 2, 1'b0, 16'h6060, 1'b0, 1'b1, 1'b0};
        run_vec(vb, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
